// File: rtl/flipdot_frame_sched.sv
// Samples the centred capture window into a ping-pong binary dot frame and hands it to a flipdot sender.
// Build option: FLIPDOT_DROPCNT_EN enables the saturating dropped-frame counter on o_drop_cnt.
module flipdot_frame_sched #(
  parameter int DOT_COLS = 28,
  parameter int DOT_ROWS = 14,
  parameter int H_STEP   = 8,
  parameter int V_STEP   = 8,
  parameter int THRESH   = 128,
  localparam int RW      = $clog2(DOT_ROWS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_vs,
  input  logic                i_de,
  input  logic                i_activ_c,
  input  logic [7:0]          i_pix_y,
  input  logic [RW-1:0]       i_rd_row,
  output logic [DOT_COLS-1:0] o_rd_data,
  output logic                o_frame_valid,
  input  logic                i_frame_done,
  output logic [7:0]          o_drop_cnt
);
  localparam int XW  = $clog2(H_STEP);
  localparam int YW  = $clog2(V_STEP);
  localparam int CW  = $clog2(DOT_COLS + 1);
  localparam int RCW = $clog2(DOT_ROWS + 1);
  localparam int CIW = $clog2(DOT_COLS);
  localparam logic [XW-1:0]  L_XS_SMP  = XW'(H_STEP / 2);
  localparam logic [XW-1:0]  L_XS_MAX  = XW'(H_STEP - 1);
  localparam logic [YW-1:0]  L_YS_SMP  = YW'(V_STEP / 2);
  localparam logic [YW-1:0]  L_YS_MAX  = YW'(V_STEP - 1);
  localparam logic [CW-1:0]  L_COL_END = CW'(DOT_COLS);
  localparam logic [RCW-1:0] L_ROW_END = RCW'(DOT_ROWS);
  localparam logic [RW:0]    L_RD_END  = (RW + 1)'(DOT_ROWS);
  localparam logic [7:0]     L_THRESH  = 8'(THRESH);

  typedef enum logic {SYNC, CAPTURE} state_t;

  state_t              r_state;
  logic                r_vs;
  logic                r_activ;
  logic                r_sel;     // write buffer index; the sender reads ~r_sel
  logic                r_valid;
  logic [XW-1:0]       r_xs;
  logic [YW-1:0]       r_ys;
  logic [CW-1:0]       r_col;
  logic [RCW-1:0]      r_row;
  logic [DOT_COLS-1:0] r_buf [2][DOT_ROWS];
  logic [DOT_COLS-1:0] r_rd_data;

  logic w_vs_rise;
  logic w_pix;
  logic w_line_end;
  logic w_sample;
  logic w_free;
  logic w_rd_ok;

  assign w_vs_rise  = i_vs & ~r_vs;
  assign w_pix      = i_activ_c & i_de;
  assign w_line_end = r_activ & ~i_activ_c;
  assign w_sample   = w_pix && (r_xs == L_XS_SMP) && (r_ys == L_YS_SMP) &&
                      (r_col < L_COL_END) && (r_row < L_ROW_END);
  // A release arriving with the frame boundary frees the read buffer for this commit.
  assign w_free     = ~r_valid | i_frame_done;
  assign w_rd_ok    = {1'b0, i_rd_row} < L_RD_END;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= SYNC;
      r_vs      <= 1'b0;
      r_activ   <= 1'b0;
      r_sel     <= 1'b0;
      r_valid   <= 1'b0;
      r_xs      <= '0;
      r_ys      <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_rd_data <= '0;
      for (int r = 0; r < DOT_ROWS; r++) begin
        r_buf[0][r] <= '0;
        r_buf[1][r] <= '0;
      end
    end else begin
      r_vs      <= i_vs;
      r_activ   <= i_activ_c;
      r_rd_data <= w_rd_ok ? r_buf[~r_sel][i_rd_row] : '0;
      if (i_frame_done && r_valid) r_valid <= 1'b0;

      if (w_vs_rise) begin
        r_xs  <= '0;
        r_ys  <= '0;
        r_col <= '0;
        r_row <= '0;
        if (r_state == SYNC) begin
          r_state <= CAPTURE;
          for (int r = 0; r < DOT_ROWS; r++) r_buf[r_sel][r] <= '0;
        end else if (w_free) begin
          r_sel   <= ~r_sel;
          r_valid <= 1'b1;
          for (int r = 0; r < DOT_ROWS; r++) r_buf[~r_sel][r] <= '0;
        end else begin
          for (int r = 0; r < DOT_ROWS; r++) r_buf[r_sel][r] <= '0;
        end
      end else if (r_state == CAPTURE) begin
        if (w_sample)
          r_buf[r_sel][r_row[RW-1:0]][r_col[CIW-1:0]] <= (i_pix_y >= L_THRESH);
        if (w_pix) begin
          if (r_xs == L_XS_MAX) begin
            r_xs <= '0;
            if (r_col < L_COL_END) r_col <= r_col + 1'b1;
          end else begin
            r_xs <= r_xs + 1'b1;
          end
        end else if (w_line_end) begin
          r_xs  <= '0;
          r_col <= '0;
          if (r_ys == L_YS_MAX) begin
            r_ys <= '0;
            if (r_row < L_ROW_END) r_row <= r_row + 1'b1;
          end else begin
            r_ys <= r_ys + 1'b1;
          end
        end
      end
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_frame_valid = r_valid;

`ifdef FLIPDOT_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if ((r_state == CAPTURE) && w_vs_rise && !w_free && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_flipdot_frame_sched.sv
// Self-checking bench for flipdot_frame_sched: table of window/pattern frames plus
// hand-written drop, release-at-boundary and mid-capture reset sequences.
module tb_flipdot_frame_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        vs;
  logic        de;
  logic        activ;
  logic [7:0]  pix;
  logic [3:0]  rd_row;
  logic [27:0] rd_data;
  logic        frame_valid;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [27:0] sb_q[$];

`ifdef FLIPDOT_DROPCNT_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  typedef struct {
    int          width;
    int          height;
    int          mode;
    logic [27:0] exp_row;
    int          nrows;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  flipdot_frame_sched dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_vs         (vs),
    .i_de         (de),
    .i_activ_c    (activ),
    .i_pix_y      (pix),
    .i_rd_row     (rd_row),
    .o_rd_data    (rd_data),
    .o_frame_valid(frame_valid),
    .i_frame_done (frame_done),
    .o_drop_cnt   (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int x);
    case (mode)
      0:       return 8'd200;
      1:       return (x >= 16 && x <= 23) ? 8'd200 : 8'd0;
      2:       return ((x / 8) % 2 == 0) ? 8'd128 : 8'd127;
      default: return 8'd100;
    endcase
  endfunction

  // Only lines at sub-line 4 are sampled, so the others are kept one pixel wide.
  task automatic video_frame(input int width, input int height, input int mode);
    for (int l = 0; l < height; l++) begin
      int len;
      len = ((l % 8) == 4) ? width : 1;
      for (int x = 0; x < len; x++) begin
        if (x == 10) begin
          activ = 1'b1; de = 1'b0; pix = 8'hFF;
          tick();
        end
        activ = 1'b1; de = 1'b1; pix = pix_val(mode, x);
        tick();
      end
      activ = 1'b0; de = 1'b0; pix = 8'h00;
      tick();
      tick();
    end
  endtask

  task automatic vs_pulse(input bit with_done);
    vs = 1'b1; frame_done = with_done;
    tick();
    vs = 1'b0; frame_done = 1'b0;
    tick();
  endtask

  task automatic read_rows(input string name, input logic [27:0] exp, input int nrows);
    for (int r = 0; r < 16; r++) begin
      rd_row = 4'(r);
      sb_q.push_back((r < nrows) ? exp : 28'h0);
      tick();
      check($sformatf("%s row%0d", name, r), {4'h0, rd_data}, {4'h0, sb_q.pop_front()});
    end
  endtask

  initial begin
    vecs[0] = '{224, 112, 0, 28'hFFFFFFF, 14};
    vecs[1] = '{224, 112, 1, 28'h0000004, 14};
    vecs[2] = '{100, 112, 0, 28'h0000FFF, 14};
    vecs[3] = '{300, 112, 0, 28'hFFFFFFF, 14};
    vecs[4] = '{224,  60, 0, 28'hFFFFFFF,  7};
    vecs[5] = '{224, 112, 2, 28'h5555555, 14};
    vecs[6] = '{224, 112, 3, 28'h0000000, 14};
    vecs[7] = '{224, 140, 1, 28'h0000004, 14};

    rst = 1'b1; vs = 1'b0; de = 1'b0; activ = 1'b0; pix = 8'h00;
    rd_row = 4'd0; frame_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset valid", {31'h0, frame_valid}, 32'h0);
    check("reset rd_data", {4'h0, rd_data}, 32'h0);
    check("reset drop", {24'h0, drop_cnt}, 32'h0);

    // Frame seen in SYNC is never committed.
    video_frame(224, 112, 0);
    vs_pulse(1'b0);
    check("sync discard valid", {31'h0, frame_valid}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      video_frame(vecs[i].width, vecs[i].height, vecs[i].mode);
      vs_pulse(1'b0);
      check($sformatf("vec%0d valid", i), {31'h0, frame_valid}, 32'h1);
      read_rows($sformatf("vec%0d", i), vecs[i].exp_row, vecs[i].nrows);
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      check($sformatf("vec%0d released", i), {31'h0, frame_valid}, 32'h0);
    end
    check("no drops in table", {24'h0, drop_cnt}, 32'h0);

    // Sender stays busy over three frame ends: first commits, two are dropped.
    video_frame(224, 112, 1);
    vs_pulse(1'b0);
    check("busy first valid", {31'h0, frame_valid}, 32'h1);
    video_frame(224, 112, 0);
    vs_pulse(1'b0);
    video_frame(224, 112, 0);
    vs_pulse(1'b0);
    check("busy still valid", {31'h0, frame_valid}, 32'h1);
    read_rows("busy held", 28'h0000004, 14);
    check("drop count", {24'h0, drop_cnt}, EXP_DROP);

    // Release in the same cycle as the frame boundary: swap, no drop.
    video_frame(224, 112, 2);
    vs_pulse(1'b1);
    check("done+vs valid", {31'h0, frame_valid}, 32'h1);
    read_rows("done+vs data", 28'h5555555, 14);
    check("done+vs drop", {24'h0, drop_cnt}, EXP_DROP);

    // Reset in the middle of a capture while a frame is pending.
    video_frame(224, 20, 0);
    activ = 1'b1; de = 1'b1; pix = 8'd200;
    tick();
    rd_row = 4'd0;
    rst = 1'b1; activ = 1'b0; de = 1'b0;
    tick();
    check("midrst valid", {31'h0, frame_valid}, 32'h0);
    check("midrst rd_data", {4'h0, rd_data}, 32'h0);
    check("midrst drop", {24'h0, drop_cnt}, 32'h0);
    rst = 1'b0;
    tick();
    video_frame(224, 112, 0);
    vs_pulse(1'b0);
    check("post-rst sync discard", {31'h0, frame_valid}, 32'h0);
    video_frame(224, 112, 1);
    vs_pulse(1'b0);
    check("post-rst valid", {31'h0, frame_valid}, 32'h1);
    read_rows("post-rst data", 28'h0000004, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
